// File: rtl/reg_mst_fsm.sv
// APB-to-register-FSM bridge: turns one APB setup phase into a single request
// toward the slave FSM, waits for its ack (or times out) and answers on APB.
module reg_mst_fsm #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic                  mst__fsm__req_vld,
  output logic                  mst__fsm__rd_en,
  output logic                  mst__fsm__wr_en,
  output logic [ADDR_WIDTH-1:0] mst__fsm__addr,
  output logic [DATA_WIDTH-1:0] mst__fsm__wr_data,
  output logic                  mst__fsm__sync_reset,
  input  logic                  fsm__mst__ack_vld,
  input  logic [DATA_WIDTH-1:0] fsm__mst__rd_data,
  output logic                  mst_is_idle
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RESP     = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t                state, state_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic                  req_vld_nxt, rd_en_nxt, wr_en_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt, prdata_nxt;
  logic                  pready_nxt, pslverr_nxt, sync_reset_nxt;

  // Every output is computed one cycle ahead so it leaves a flop; the
  // addr/wr_data/rd_en/wr_en registers double as the latched request.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    req_vld_nxt    = 1'b0;
    rd_en_nxt      = mst__fsm__rd_en;
    wr_en_nxt      = mst__fsm__wr_en;
    addr_nxt       = mst__fsm__addr;
    wr_data_nxt    = mst__fsm__wr_data;
    pready_nxt     = 1'b0;
    pslverr_nxt    = 1'b0;
    prdata_nxt     = '0;
    sync_reset_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_nxt   = ST_WAIT_ACK;
          cnt_nxt     = '0;
          req_vld_nxt = 1'b1;
          wr_en_nxt   = pwrite;
          rd_en_nxt   = !pwrite;
          addr_nxt    = paddr;
          wr_data_nxt = pwdata;
        end
      end
      ST_WAIT_ACK: begin
        if (fsm__mst__ack_vld) begin
          // Ack beats a coincident timeout.
          state_nxt   = ST_RESP;
          pready_nxt  = 1'b1;
          prdata_nxt  = mst__fsm__wr_en ? '0 : fsm__mst__rd_data;
          rd_en_nxt   = 1'b0;
          wr_en_nxt   = 1'b0;
          addr_nxt    = '0;
          wr_data_nxt = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt      = ST_RESP;
          pready_nxt     = 1'b1;
          pslverr_nxt    = 1'b1;
          sync_reset_nxt = 1'b1;
          rd_en_nxt      = 1'b0;
          wr_en_nxt      = 1'b0;
          addr_nxt       = '0;
          wr_data_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt   = ST_IDLE;
        rd_en_nxt   = 1'b0;
        wr_en_nxt   = 1'b0;
        addr_nxt    = '0;
        wr_data_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      mst__fsm__req_vld    <= 1'b0;
      mst__fsm__rd_en      <= 1'b0;
      mst__fsm__wr_en      <= 1'b0;
      mst__fsm__addr       <= '0;
      mst__fsm__wr_data    <= '0;
      mst__fsm__sync_reset <= 1'b0;
      pready               <= 1'b0;
      pslverr              <= 1'b0;
      prdata               <= '0;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      mst__fsm__req_vld    <= req_vld_nxt;
      mst__fsm__rd_en      <= rd_en_nxt;
      mst__fsm__wr_en      <= wr_en_nxt;
      mst__fsm__addr       <= addr_nxt;
      mst__fsm__wr_data    <= wr_data_nxt;
      mst__fsm__sync_reset <= sync_reset_nxt;
      pready               <= pready_nxt;
      pslverr              <= pslverr_nxt;
      prdata               <= prdata_nxt;
    end
  end

  assign mst_is_idle = (state == ST_IDLE);

endmodule

// File: tb/tb_reg_mst_fsm.sv
// Directed bench for reg_mst_fsm with TIMEOUT_CYC=4; all expected values are
// hand-derived cycle by cycle from the setup cycle T.
module tb_reg_mst_fsm;

  localparam int AW = 64;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;
  logic          req_vld, rd_en, wr_en, sync_reset, is_idle;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wr_data;
  logic          ack_vld = 1'b0;
  logic [DW-1:0] rd_data = '0;

  int n_cmp = 0;
  int n_err = 0;

  reg_mst_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(4)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .psel                 (psel),
    .penable              (penable),
    .pwrite               (pwrite),
    .paddr                (paddr),
    .pwdata               (pwdata),
    .pready               (pready),
    .prdata               (prdata),
    .pslverr              (pslverr),
    .mst__fsm__req_vld    (req_vld),
    .mst__fsm__rd_en      (rd_en),
    .mst__fsm__wr_en      (wr_en),
    .mst__fsm__addr       (m_addr),
    .mst__fsm__wr_data    (m_wr_data),
    .mst__fsm__sync_reset (sync_reset),
    .fsm__mst__ack_vld    (ack_vld),
    .fsm__mst__rd_data    (rd_data),
    .mst_is_idle          (is_idle)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample #1 after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    step();
    penable = 1'b1;
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; ack_vld = 1'b0; rd_data = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_pready"}, 64'(pready), 64'd0);
    check({tag, "_pslverr"}, 64'(pslverr), 64'd0);
    check({tag, "_prdata"}, 64'(prdata), 64'd0);
    check({tag, "_sync"}, 64'(sync_reset), 64'd0);
    check({tag, "_req"}, 64'(req_vld), 64'd0);
    check({tag, "_rwen"}, 64'({rd_en, wr_en}), 64'd0);
    check({tag, "_addr"}, m_addr, 64'd0);
    check({tag, "_wdata"}, 64'(m_wr_data), 64'd0);
  endtask

  initial begin
    #1;
    check_quiet("rst");
    check("rst_idle", 64'(is_idle), 64'd1);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    step();

    // Write, ack at T+2
    setup(1'b1, 64'h10, 32'hA5A5_0001);
    check("wr_t1_req", 64'(req_vld), 64'd1);
    check("wr_t1_en", 64'({rd_en, wr_en}), 64'b01);
    check("wr_t1_addr", m_addr, 64'h10);
    check("wr_t1_wdata", 64'(m_wr_data), 64'hA5A5_0001);
    check("wr_t1_idle", 64'(is_idle), 64'd0);
    check("wr_t1_pready", 64'(pready), 64'd0);
    step();
    check("wr_t2_req", 64'(req_vld), 64'd0);
    check("wr_t2_en", 64'({rd_en, wr_en}), 64'b01);
    check("wr_t2_addr", m_addr, 64'h10);
    ack_vld = 1'b1; rd_data = 32'hDEAD_BEEF;
    step();
    ack_vld = 1'b0;
    check("wr_t3_pready", 64'(pready), 64'd1);
    check("wr_t3_pslverr", 64'(pslverr), 64'd0);
    check("wr_t3_prdata", 64'(prdata), 64'd0);
    check("wr_t3_en", 64'({rd_en, wr_en}), 64'b00);
    check("wr_t3_sync", 64'(sync_reset), 64'd0);
    step();
    check_quiet("wr_t4");
    check("wr_t4_idle", 64'(is_idle), 64'd1);
    bus_idle();
    step();

    // Read, ack at T+1, then back-to-back setup in the cycle after RESP
    setup(1'b0, 64'h20, 32'h0);
    check("rd_t1_req", 64'(req_vld), 64'd1);
    check("rd_t1_en", 64'({rd_en, wr_en}), 64'b10);
    check("rd_t1_addr", m_addr, 64'h20);
    ack_vld = 1'b1; rd_data = 32'h1234_5678;
    step();
    ack_vld = 1'b0; psel = 1'b0; penable = 1'b0;
    check("rd_t2_pready", 64'(pready), 64'd1);
    check("rd_t2_prdata", 64'(prdata), 64'h1234_5678);
    check("rd_t2_pslverr", 64'(pslverr), 64'd0);
    check("rd_t2_req", 64'(req_vld), 64'd0);
    step();
    check("rd_t3_idle", 64'(is_idle), 64'd1);
    check("rd_t3_prdata", 64'(prdata), 64'd0);
    setup(1'b1, 64'h30, 32'h0000_00C3);
    check("b2b_req", 64'(req_vld), 64'd1);
    check("b2b_addr", m_addr, 64'h30);
    check("b2b_wdata", 64'(m_wr_data), 64'hC3);
    ack_vld = 1'b1;
    step();
    ack_vld = 1'b0;
    check("b2b_pready", 64'(pready), 64'd1);
    bus_idle();
    step();

    // Timeout: no ack, four WAIT_ACK cycles then error response
    setup(1'b0, 64'h40, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_w%0d_idle", i), 64'(is_idle), 64'd0);
      check($sformatf("to_w%0d_pready", i), 64'(pready), 64'd0);
      check($sformatf("to_w%0d_rden", i), 64'(rd_en), 64'd1);
      step();
    end
    check("to_pready", 64'(pready), 64'd1);
    check("to_pslverr", 64'(pslverr), 64'd1);
    check("to_prdata", 64'(prdata), 64'd0);
    check("to_sync", 64'(sync_reset), 64'd1);
    check("to_rden", 64'(rd_en), 64'd0);
    step();
    check_quiet("to_after");
    check("to_after_idle", 64'(is_idle), 64'd1);
    bus_idle();
    step();

    // Ack in the 4th WAIT_ACK cycle, coinciding with the timeout point
    setup(1'b0, 64'h50, 32'h0);
    step(); step(); step();
    check("ack4_idle", 64'(is_idle), 64'd0);
    ack_vld = 1'b1; rd_data = 32'hCAFE_F00D;
    step();
    ack_vld = 1'b0;
    check("ack4_pready", 64'(pready), 64'd1);
    check("ack4_pslverr", 64'(pslverr), 64'd0);
    check("ack4_sync", 64'(sync_reset), 64'd0);
    check("ack4_prdata", 64'(prdata), 64'hCAFE_F00D);
    bus_idle();
    step();

    // Spurious ack in IDLE, then reset during the 2nd WAIT_ACK cycle
    ack_vld = 1'b1; rd_data = 32'h5555_AAAA;
    step(); step();
    check_quiet("spur");
    check("spur_idle", 64'(is_idle), 64'd1);
    ack_vld = 1'b0;
    setup(1'b1, 64'h60, 32'h7777_0000);
    step();
    check("rst_w2_wren", 64'(wr_en), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_quiet("arst");
    check("arst_idle", 64'(is_idle), 64'd1);
    bus_idle();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rel%0d_pready", i), 64'(pready), 64'd0);
      check($sformatf("rel%0d_sync", i), 64'(sync_reset), 64'd0);
      check($sformatf("rel%0d_idle", i), 64'(is_idle), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_mst_fsm.md
REG_MST_FSM -- requirements
Module: reg_mst_fsm

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, address width on both sides.
REQ-002 Parameter DATA_WIDTH, default 32, data width on both sides.
REQ-003 Parameter TIMEOUT_CYC, default 255, range 1..255, WAIT_ACK cycles without ack before abort.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 psel  in  1  APB select.
REQ-007 penable  in  1  APB access phase.
REQ-008 pwrite  in  1  APB direction; 1=write.
REQ-009 paddr  in  ADDR_WIDTH  APB address.
REQ-010 pwdata  in  DATA_WIDTH  APB write data.
REQ-011 pready  out  1  APB transfer complete.
REQ-012 prdata  out  DATA_WIDTH  APB read data.
REQ-013 pslverr  out  1  APB error (timeout).
REQ-014 mst__fsm__req_vld  out  1  request strobe to slave FSM.
REQ-015 mst__fsm__rd_en / mst__fsm__wr_en  out  1 each  access type.
REQ-016 mst__fsm__addr  out  ADDR_WIDTH  latched address.
REQ-017 mst__fsm__wr_data  out  DATA_WIDTH  latched write data.
REQ-018 mst__fsm__sync_reset  out  1  abort pulse to slave FSM.
REQ-019 fsm__mst__ack_vld  in  1  slave acknowledge.
REQ-020 fsm__mst__rd_data  in  DATA_WIDTH  slave read data, valid with ack.
REQ-021 mst_is_idle  out  1  high when state is IDLE.

Function
REQ-022 States: IDLE, WAIT_ACK, RESP; all outputs registered except mst_is_idle (state decode).
REQ-023 IDLE: psel=1 and penable=0 -> latch pwrite/paddr/pwdata, go WAIT_ACK; otherwise stay.
REQ-024 mst__fsm__req_vld high exactly first WAIT_ACK cycle only.
REQ-025 Throughout WAIT_ACK: addr/wr_data hold latched values; wr_en=latched pwrite, rd_en=~latched pwrite; all four zero outside WAIT_ACK.
REQ-026 WAIT_ACK with ack_vld=1 (including first cycle) -> capture fsm__mst__rd_data into prdata (zero on write), pslverr=0, go RESP.
REQ-027 Timeout counter: 8 bits, cleared on WAIT_ACK entry, +1 per WAIT_ACK cycle with ack_vld=0.
REQ-028 WAIT_ACK cycle with counter==TIMEOUT_CYC-1 and ack_vld=0 -> go RESP with pslverr=1, prdata=0, mst__fsm__sync_reset=1.
REQ-029 Ack and timeout same cycle: ack wins, no error, no sync_reset.
REQ-030 RESP lasts exactly one cycle: pready=1, then IDLE unconditionally.
REQ-031 pready, pslverr, sync_reset high only in RESP; prdata zero outside RESP.
REQ-032 Ack_vld outside WAIT_ACK is ignored (no state/data change).
REQ-033 psel/penable changes during WAIT_ACK do not abort the transfer.
REQ-034 Latency: setup at cycle T -> req_vld T+1 -> ack at T+1 gives pready at T+2; back-to-back setup accepted in the cycle after RESP.

Reset
REQ-035 rstn low -> state IDLE, counter 0, latched regs 0, every output 0 except mst_is_idle=1, immediately and asynchronously.
REQ-036 Reset mid WAIT_ACK discards transfer; no pready or sync_reset on release.

Verification
REQ-037 Write paddr=0x10, pwdata=0xA5A5_0001, ack at T+2 -> req_vld only T+1, wr_en=1 T+1..T+2, pready=1 T+3, pslverr=0.
REQ-038 Read paddr=0x20, ack at T+1 with rd_data=0x1234_5678 -> prdata=0x1234_5678, pready=1 at T+2.
REQ-039 TIMEOUT_CYC=4, no ack -> WAIT_ACK 4 cycles, then RESP with pslverr=1, prdata=0, sync_reset=1 for one cycle.
REQ-040 TIMEOUT_CYC=4, ack in 4th WAIT_ACK cycle -> pslverr=0, sync_reset=0, prdata=rd_data.
REQ-041 Spurious ack_vld in IDLE, then rstn low in 2nd WAIT_ACK cycle -> no effect in IDLE; outputs 0, mst_is_idle=1, no pready after release.
